// File: rtl/e18_trace_pkg.sv
// Shared definitions for the e18 output tracer.
// Holds the observed vector width, the trace entry width, the tracer
// state encoding and the default MISR taps/seed.
package e18_trace_pkg;

  localparam int E18_Y_W     = 12;
  localparam int E18_TS_W    = 16;
  localparam int E18_ENTRY_W = E18_TS_W + E18_Y_W;

  localparam logic [E18_Y_W-1:0] E18_MISR_POLY = 12'h829;
  localparam logic [E18_Y_W-1:0] E18_MISR_SEED = 12'h000;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRACING = 2'd1,
    FROZEN  = 2'd2
  } state_e;

endpackage

// File: rtl/e18_out_tracer_trace_fifo.sv
// trace_fifo: DEPTH x W synchronous FIFO for trace entries.
// Ports:
//   clk, rst (async, active-high), clr (sync clear, wins over push/pop)
//   push/din  - write an entry; ignored when full unless a pop happens too
//   pop       - remove the head entry; ignored when empty
//   dout      - head entry, zero while empty
//   empty/full/count - occupancy status
module trace_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // When full, a push is only legal alongside a pop: the write lands in the
  // slot the head is vacating on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is gated to zero while empty so the port reads 0 after reset/clr.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/e18_out_tracer.sv
// e18_out_tracer: observation stage for the e18 controller outputs.
// Logs every change of y (with a free-running cycle timestamp) into a trace
// FIFO drained over tr_valid/tr_ready, and folds every enabled sample into a
// MISR signature.
// Ports:
//   clk, rst (async, active-high), clr (sync clear, same effect as rst)
//   sample_en, y           - observed vector, valid when sample_en=1
//   tr_valid/tr_ready/tr_data - trace drain port, tr_data = {ts, y}
//   count                  - FIFO occupancy
//   overflow               - sticky, a change was dropped on a full FIFO
//   signature              - current MISR value
module e18_out_tracer
  import e18_trace_pkg::*;
#(
  parameter int             Y_W          = E18_Y_W,
  parameter int             DEPTH        = 16,
  parameter int             TS_W         = E18_TS_W,
  parameter logic [Y_W-1:0] MISR_POLY    = E18_MISR_POLY,
  parameter logic [Y_W-1:0] MISR_SEED    = E18_MISR_SEED,
  parameter bit             STOP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     sample_en,
  input  logic [Y_W-1:0]           y,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [TS_W+Y_W-1:0]      tr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [Y_W-1:0]           signature
);

  logic [TS_W-1:0] ts_q;
  state_e          state_q, state_d;
  logic [Y_W-1:0]  last_y_q;
  logic [Y_W-1:0]  sig_q, sig_d;
  logic            overflow_q;

  logic active;
  logic change;
  logic pop;
  logic full;
  logic empty;
  logic drop;
  logic push;

  always_comb begin
    active = sample_en && (state_q != FROZEN);
    // The first sample after arming is logged regardless of last_y.
    change = active && ((state_q == ARMED) || (y != last_y_q));
    pop    = tr_valid && tr_ready;
    drop   = change && full && !pop;
    push   = change && !drop;
    sig_d  = {sig_q[Y_W-2:0], 1'b0} ^ (sig_q[Y_W-1] ? MISR_POLY : '0) ^ y;

    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (sample_en) state_d = TRACING;
        if (drop && STOP_ON_FULL) state_d = FROZEN;
      end
      TRACING: begin
        if (drop && STOP_ON_FULL) state_d = FROZEN;
      end
      FROZEN:  state_d = FROZEN;
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      state_q    <= ARMED;
      last_y_q   <= '0;
      sig_q      <= MISR_SEED;
      overflow_q <= 1'b0;
    end else if (clr) begin
      ts_q       <= '0;
      state_q    <= ARMED;
      last_y_q   <= '0;
      sig_q      <= MISR_SEED;
      overflow_q <= 1'b0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      state_q <= state_d;
      // last_y follows every change, including dropped ones, so the next
      // change is measured against what was actually on y.
      if (change) last_y_q <= y;
      if (active) sig_q <= sig_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  trace_fifo #(
    .W     (TS_W + Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   ({ts_q, y}),
    .pop   (pop),
    .dout  (tr_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign tr_valid  = !empty;
  assign overflow  = overflow_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_e18_out_tracer.sv
// Bench for e18_out_tracer: two instances (drop-and-continue and
// stop-on-full) share all inputs and are compared every cycle against a
// queue-based reference model, plus directed checks of the key scenarios.
module tb_e18_out_tracer;
  import e18_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] y = '0;
  logic        tr_ready = 1'b0;

  logic        tr_valid  [2];
  logic [27:0] tr_data   [2];
  logic [4:0]  count     [2];
  logic        overflow  [2];
  logic [11:0] signature [2];

  always #5 clk = ~clk;

  e18_out_tracer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .y(y),
    .tr_valid(tr_valid[0]), .tr_ready(tr_ready), .tr_data(tr_data[0]),
    .count(count[0]), .overflow(overflow[0]), .signature(signature[0]));

  e18_out_tracer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .y(y),
    .tr_valid(tr_valid[1]), .tr_ready(tr_ready), .tr_data(tr_data[1]),
    .count(count[1]), .overflow(overflow[1]), .signature(signature[1]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [27:0] mq0[$];
  logic [27:0] mq1[$];
  logic [15:0] m_ts;
  bit          m_armed  [2];
  bit          m_frozen [2];
  bit          m_ovf    [2];
  logic [11:0] m_last   [2];
  logic [11:0] m_sig    [2];

  function automatic int q_size(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [27:0] q_front(input int k);
    if (q_size(k) == 0) return '0;
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic q_pop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic q_push(input int k, input logic [27:0] v);
    if (k == 0) mq0.push_back(v); else mq1.push_back(v);
  endtask

  function automatic logic [11:0] misr(input logic [11:0] s, input logic [11:0] v);
    logic [11:0] r;
    r = {s[10:0], 1'b0};
    if (s[11]) r = r ^ 12'h829;
    return r ^ v;
  endfunction

  task automatic model_reset();
    m_ts = '0;
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_armed[k]  = 1'b1;
      m_frozen[k] = 1'b0;
      m_ovf[k]    = 1'b0;
      m_last[k]   = '0;
      m_sig[k]    = 12'h000;
    end
  endtask

  // One clock edge of behaviour, using the inputs as they were before it.
  task automatic model_edge();
    if (rst || clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int  n;
      bit  do_pop, active, change;
      logic [27:0] e;
      n      = q_size(k);
      do_pop = (n > 0) && tr_ready;
      active = sample_en && !m_frozen[k];
      change = active && (m_armed[k] || (y != m_last[k]));
      if (do_pop) begin
        e = q_front(k);
        $display("pop u%0d ts=%0d y=%03h", k, e[27:12], e[11:0]);
        q_pop(k);
      end
      if (change) begin
        if (n < DEPTH || do_pop) q_push(k, {m_ts, y});
        else begin
          m_ovf[k] = 1'b1;
          if (k == 1) m_frozen[k] = 1'b1;
        end
        m_last[k]  = y;
        m_armed[k] = 1'b0;
      end
      if (active) m_sig[k] = misr(m_sig[k], y);
    end
    m_ts = m_ts + 16'd1;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.tr_valid", k), 64'(tr_valid[k]), 64'(q_size(k) > 0));
      chk($sformatf("u%0d.count", k), 64'(count[k]), 64'(q_size(k)));
      chk($sformatf("u%0d.overflow", k), 64'(overflow[k]), 64'(m_ovf[k]));
      chk($sformatf("u%0d.signature", k), 64'(signature[k]), 64'(m_sig[k]));
      chk($sformatf("u%0d.tr_data", k), 64'(tr_data[k]), 64'(q_front(k)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [11:0] sig_hold;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    check_all();
    chk("reset.count", 64'(count[0]), 64'd0);
    chk("reset.signature", 64'(signature[0]), 64'h000);
    step();
    step();
    rst = 1'b0;

    // First sample lands at ts=3.
    repeat (3) step();
    sample_en = 1'b1;
    y = 12'h001;
    step();
    chk("first.tr_valid", 64'(tr_valid[0]), 64'd1);
    chk("first.tr_data", 64'(tr_data[0]), 64'({16'd3, 12'h001}));
    chk("first.signature", 64'(signature[0]), 64'h001);
    step();
    chk("second.signature", 64'(signature[0]), 64'h003);
    repeat (4) step();
    chk("repeat.count", 64'(count[0]), 64'd1);
    sample_en = 1'b0;
    tr_ready  = 1'b1;
    repeat (2) step();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      sample_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) y = 12'($urandom);
      tr_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr.count", 64'(count[0]), 64'd0);
    chk("clr.signature", 64'(signature[1]), 64'h000);

    // Overflow: 17 distinct changes with no drain.
    tr_ready  = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      y = 12'h5A0 + 12'(i);
      step();
    end
    chk("ovf.u0.count", 64'(count[0]), 64'd16);
    chk("ovf.u0.overflow", 64'(overflow[0]), 64'd1);
    chk("ovf.u1.overflow", 64'(overflow[1]), 64'd1);
    sig_hold = signature[1];
    for (int i = 0; i < 4; i++) begin
      y = y ^ 12'hFFF;
      step();
    end
    chk("frozen.signature", 64'(signature[1]), 64'(sig_hold));
    chk("frozen.count", 64'(count[1]), 64'd16);
    sample_en = 1'b0;
    tr_ready  = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("ovf.drain", 64'(tr_data[0][11:0]), 64'(12'h5A0 + 12'(j)));
      step();
    end
    chk("ovf.drained", 64'(count[0]), 64'd0);

    // clr leaves FROZEN; the first sample after it is logged unconditionally.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("unfreeze.overflow", 64'(overflow[1]), 64'd0);
    chk("unfreeze.signature", 64'(signature[1]), 64'h000);
    sample_en = 1'b1;
    tr_ready  = 1'b0;
    step();
    chk("armed.count", 64'(count[1]), 64'd1);

    // Full FIFO with a simultaneous pop and push.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      y = 12'h300 + 12'(i);
      step();
    end
    chk("full.count", 64'(count[0]), 64'd16);
    tr_ready = 1'b1;
    y = 12'h3FF;
    step();
    chk("pushpop.count", 64'(count[0]), 64'd16);
    chk("pushpop.overflow", 64'(overflow[0]), 64'd0);
    sample_en = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("pushpop.drain", 64'(tr_data[0][11:0]),
          64'((j < 15) ? (12'h301 + 12'(j)) : 12'h3FF));
      step();
    end

    // Asynchronous reset in the middle of a drain.
    sample_en = 1'b1;
    tr_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y = 12'h700 + 12'(i);
      step();
    end
    sample_en = 1'b0;
    tr_ready  = 1'b1;
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst.tr_valid", 64'(tr_valid[0]), 64'd0);
    chk("arst.count", 64'(count[0]), 64'd0);
    chk("arst.u1.count", 64'(count[1]), 64'd0);
    step();
    rst = 1'b0;
    sample_en = 1'b1;
    y = 12'h0AB;
    step();
    chk("arst.ts0", 64'(tr_data[0]), 64'({16'd0, 12'h0AB}));

    for (int i = 0; i < 40; i++) begin
      sample_en = 1'($urandom_range(0, 1));
      y = 12'($urandom);
      tr_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
